// File: rtl/read_strobe_sampler.sv
// Samples an asynchronous bus on each rising edge of the divided read clock, debounces it
// and hands each new stable value over VALID/READY. Optional PARITY output: SAMPLER_PARITY_EN.
`timescale 1ns/1ps

module read_strobe_sampler #(
  parameter int DATA_WIDTH   = 8,
  parameter int STABLE_COUNT = 4
) (
  input  logic                  IN_50Mhz,
  input  logic                  RST_N,
  input  logic                  READ_CLK,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  VALID,
  input  logic                  READY,
  output logic                  OVERRUN,
  input  logic                  CLEAR_OVR
`ifdef SAMPLER_PARITY_EN
  ,
  output logic                  PARITY
`endif
);

  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_COUNT);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] sync_meta;
  logic [DATA_WIDTH-1:0] sync_data;
  logic                  read_clk_d;
  logic                  strobe;
  logic [DATA_WIDTH-1:0] candidate;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  same_value;
  logic                  reach;
  logic                  delivered;
  logic                  capture;

  // read_clk_d resets high so a READ_CLK already high at release is not seen as an edge.
  always_ff @(posedge IN_50Mhz or negedge RST_N) begin
    if (!RST_N) begin
      sync_meta  <= '0;
      sync_data  <= '0;
      read_clk_d <= 1'b1;
    end else begin
      sync_meta  <= DATA_IN;
      sync_data  <= sync_meta;
      read_clk_d <= READ_CLK;
    end
  end

  assign strobe = READ_CLK & ~read_clk_d;

  always_comb begin
    same_value = (sync_data == candidate);
    count_next = count;
    if (!same_value) begin
      count_next = CW'(1);
    end else if (count != STABLE_MAX) begin
      count_next = count + CW'(1);
    end
    // A changed value reaching the threshold in one step only happens with STABLE_COUNT=1.
    reach   = strobe & (count_next == STABLE_MAX) & (~same_value | (count != STABLE_MAX));
    capture = reach & ((sync_data != DATA_OUT) | ~delivered);
  end

  always_ff @(posedge IN_50Mhz or negedge RST_N) begin
    if (!RST_N) begin
      candidate <= '0;
      count     <= '0;
    end else if (strobe) begin
      candidate <= sync_data;
      count     <= count_next;
    end
  end

  // DATA_OUT doubles as the last delivered value used to suppress repeats.
  always_ff @(posedge IN_50Mhz or negedge RST_N) begin
    if (!RST_N) begin
      DATA_OUT  <= '0;
      delivered <= 1'b0;
    end else if (capture) begin
      DATA_OUT  <= sync_data;
      delivered <= 1'b1;
    end
  end

`ifdef SAMPLER_PARITY_EN
  always_ff @(posedge IN_50Mhz or negedge RST_N) begin
    if (!RST_N) begin
      PARITY <= 1'b0;
    end else if (capture) begin
      PARITY <= ^sync_data;
    end
  end
`endif

  always_ff @(posedge IN_50Mhz or negedge RST_N) begin
    if (!RST_N) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (capture) state_next = FULL;
      FULL:  if (READY && !capture) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  assign VALID = (state == FULL);

  // A capture on top of an unaccepted value wins over a simultaneous clear.
  always_ff @(posedge IN_50Mhz or negedge RST_N) begin
    if (!RST_N) begin
      OVERRUN <= 1'b0;
    end else if ((state == FULL) && capture && !READY) begin
      OVERRUN <= 1'b1;
    end else if (CLEAR_OVR) begin
      OVERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_read_strobe_sampler.sv
// Directed bench for read_strobe_sampler (DATA_WIDTH=8, STABLE_COUNT=4), read clock period 8 clk.
`timescale 1ns/1ps

module tb_read_strobe_sampler;

  logic       clk;
  logic       rst_n;
  logic       read_clk;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid;
  logic       ready;
  logic       overrun;
  logic       clear_ovr;
`ifdef SAMPLER_PARITY_EN
  logic       parity;
`endif

  int checks   = 0;
  int failures = 0;

  read_strobe_sampler #(.DATA_WIDTH(8), .STABLE_COUNT(4)) dut (
    .IN_50Mhz (clk),
    .RST_N    (rst_n),
    .READ_CLK (read_clk),
    .DATA_IN  (data_in),
    .DATA_OUT (data_out),
    .VALID    (valid),
    .READY    (ready),
    .OVERRUN  (overrun),
    .CLEAR_OVR(clear_ovr)
`ifdef SAMPLER_PARITY_EN
    ,
    .PARITY   (parity)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Low phase of 7 cycles with new data, then READ_CLK rises; returns one negedge after the strobe posedge.
  task automatic apply_strobe(input logic [7:0] value, input logic clr);
    read_clk = 1'b0;
    data_in  = value;
    repeat (7) @(negedge clk);
    read_clk  = 1'b1;
    clear_ovr = clr;
    @(negedge clk);
    clear_ovr = 1'b0;
  endtask

  task automatic accept_value();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    read_clk  = 1'b1;
    data_in   = 8'hFF;
    ready     = 1'b0;
    clear_ovr = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_data_out", data_out, 8'h00);
    check_output("rst_valid", valid, 1'b0);
    check_output("rst_overrun", overrun, 1'b0);
`ifdef SAMPLER_PARITY_EN
    check_output("rst_parity", parity, 1'b0);
`endif

    // Release with READ_CLK high: a false strobe would shorten the next debounce by one.
    rst_n   = 1'b1;
    data_in = 8'h00;
    repeat (6) @(negedge clk);
    check_output("release_valid", valid, 1'b0);
    for (int i = 0; i < 3; i++) apply_strobe(8'h00, 1'b0);
    check_output("release_no_false_strobe", valid, 1'b0);
    apply_strobe(8'h00, 1'b0);
    check_output("first_value_valid", valid, 1'b1);
    check_output("first_value_data", data_out, 8'h00);
    accept_value();
    check_output("first_value_accept", valid, 1'b0);

    $display("[TB] stable capture of 0xA5");
    for (int i = 0; i < 3; i++) apply_strobe(8'hA5, 1'b0);
    check_output("a5_three_strobes", valid, 1'b0);
    apply_strobe(8'hA5, 1'b0);
    check_output("a5_valid", valid, 1'b1);
    check_output("a5_data", data_out, 8'hA5);
    @(negedge clk);
    check_output("a5_hold_no_ready", valid, 1'b1);
    accept_value();
    check_output("a5_accept", valid, 1'b0);
    for (int i = 0; i < 10; i++) apply_strobe(8'hA5, 1'b0);
    check_output("a5_no_rereport", valid, 1'b0);
    check_output("a5_data_kept", data_out, 8'hA5);

    $display("[TB] bouncing bus");
    for (int i = 0; i < 8; i++) begin
      apply_strobe((i % 2 == 0) ? 8'h3D : 8'h3C, 1'b0);
      check_output("bounce_no_valid", valid, 1'b0);
    end
    for (int i = 0; i < 3; i++) apply_strobe(8'h3D, 1'b0);
    check_output("3d_three_strobes", valid, 1'b0);
    apply_strobe(8'h3D, 1'b0);
    check_output("3d_valid", valid, 1'b1);
    check_output("3d_data", data_out, 8'h3D);

    $display("[TB] overrun handling");
    accept_value();
    check_output("3d_accept", valid, 1'b0);
    for (int i = 0; i < 4; i++) apply_strobe(8'h11, 1'b0);
    check_output("11_valid", valid, 1'b1);
    check_output("11_data", data_out, 8'h11);
    check_output("11_no_overrun", overrun, 1'b0);
    for (int i = 0; i < 3; i++) apply_strobe(8'h22, 1'b0);
    check_output("22_pending_data_stable", data_out, 8'h11);
    apply_strobe(8'h22, 1'b0);
    check_output("22_overwrite_data", data_out, 8'h22);
    check_output("22_overwrite_valid", valid, 1'b1);
    check_output("22_overrun_set", overrun, 1'b1);
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    check_output("overrun_cleared", overrun, 1'b0);
    check_output("clear_keeps_valid", valid, 1'b1);
    for (int i = 0; i < 3; i++) apply_strobe(8'h33, 1'b0);
    apply_strobe(8'h33, 1'b1);
    check_output("set_beats_clear", overrun, 1'b1);
    check_output("33_data", data_out, 8'h33);
    @(negedge clk);
    check_output("overrun_sticky", overrun, 1'b1);
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    check_output("overrun_cleared_again", overrun, 1'b0);

    $display("[TB] reset mid-operation");
    accept_value();
    for (int i = 0; i < 4; i++) apply_strobe(8'hA5, 1'b0);
    check_output("a5_again_valid", valid, 1'b1);
    check_output("a5_again_data", data_out, 8'hA5);
    read_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midrst_valid", valid, 1'b0);
    check_output("midrst_data", data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) apply_strobe(8'hA5, 1'b0);
    check_output("post_rst_three_strobes", valid, 1'b0);
    apply_strobe(8'hA5, 1'b0);
    check_output("post_rst_rereport_valid", valid, 1'b1);
    check_output("post_rst_rereport_data", data_out, 8'hA5);

    $display("[TB] parity values");
    accept_value();
    for (int i = 0; i < 4; i++) apply_strobe(8'h07, 1'b0);
    check_output("07_data", data_out, 8'h07);
`ifdef SAMPLER_PARITY_EN
    check_output("07_parity", parity, 1'b1);
`endif
    accept_value();
    for (int i = 0; i < 4; i++) apply_strobe(8'h03, 1'b0);
    check_output("03_data", data_out, 8'h03);
`ifdef SAMPLER_PARITY_EN
    check_output("03_parity", parity, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
